// File: rtl/sequential_multiplier.sv
// rtl/sequential_multiplier.sv - unsigned shift-and-add multiplier, one multiplier bit per clock
module sequential_multiplier #(
    parameter int N = 8
) (
    input  logic           i_clock,
    input  logic           i_reset,
    input  logic           i_start,
    output logic           o_busy,
    output logic           o_finished,
    input  logic [N-1:0]   i_multiplicand,
    input  logic [N-1:0]   i_multiplier,
    output logic [2*N-1:0] o_product,
    output logic           o_overflow
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  mcand;
    logic [N-1:0]  acc_hi;
    logic [N-1:0]  acc_lo;
    logic [CW-1:0] count;
    logic [N:0]    sum;

    // The multiplier drains out of acc_lo as the partial product shifts in from the top.
    always_comb begin
        sum = {1'b0, acc_hi};
        if (acc_lo[0]) begin
            sum = {1'b0, acc_hi} + {1'b0, mcand};
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state      <= IDLE;
            o_busy     <= 1'b0;
            o_finished <= 1'b0;
            o_product  <= '0;
            o_overflow <= 1'b0;
            count      <= '0;
            mcand      <= '0;
            acc_hi     <= '0;
            acc_lo     <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    o_finished <= 1'b0;
                    if (i_start) begin
                        state  <= RUN;
                        o_busy <= 1'b1;
                        mcand  <= i_multiplicand;
                        acc_hi <= '0;
                        acc_lo <= i_multiplier;
                        count  <= '0;
                    end else begin
                        state  <= IDLE;
                        o_busy <= 1'b0;
                    end
                end
                RUN: begin
                    acc_hi <= sum[N:1];
                    acc_lo <= {sum[0], acc_lo[N-1:1]};
                    if (count == CW'(N - 1)) begin
                        // Publish the value produced by this final step, not the stale accumulator.
                        state      <= DONE;
                        o_busy     <= 1'b0;
                        o_finished <= 1'b1;
                        o_product  <= {sum, acc_lo[N-1:1]};
                        o_overflow <= |sum[N:1];
                    end else begin
                        count <= count + CW'(1);
                    end
                end
                default: begin
                    state      <= IDLE;
                    o_busy     <= 1'b0;
                    o_finished <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sequential_multiplier.sv
// tb/tb_sequential_multiplier.sv - self-checking bench for sequential_multiplier
module tb_sequential_multiplier;

    localparam int N = 8;

    logic           clock = 1'b0;
    logic           reset;
    logic           start;
    logic           busy;
    logic           finished;
    logic [N-1:0]   mcand_in;
    logic [N-1:0]   mplier_in;
    logic [2*N-1:0] product;
    logic           overflow;

    int             total = 0;
    int             bad   = 0;
    logic [2*N-1:0] prev_product = '0;
    logic           prev_overflow = 1'b0;

    sequential_multiplier #(.N(N)) dut (
        .i_clock        (clock),
        .i_reset        (reset),
        .i_start        (start),
        .o_busy         (busy),
        .o_finished     (finished),
        .i_multiplicand (mcand_in),
        .i_multiplier   (mplier_in),
        .o_product      (product),
        .o_overflow     (overflow)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive a request at the current time; returns just after the accepting edge.
    task automatic launch(input logic [N-1:0] a, input logic [N-1:0] b);
        start     = 1'b1;
        mcand_in  = a;
        mplier_in = b;
        @(posedge clock);
        #1;
        start     = 1'b0;
        mcand_in  = N'($urandom);
        mplier_in = N'($urandom);
    endtask

    // Follow one operation through RUN; returns at the negedge of its DONE cycle.
    task automatic track(input string tag, input logic [N-1:0] a, input logic [N-1:0] b,
                         input int inj);
        logic [2*N-1:0] exp_p;
        logic           exp_o;
        exp_p = (2*N)'(int'(a) * int'(b));
        exp_o = (int'(a) * int'(b)) > ((1 << N) - 1);
        for (int k = 1; k <= N; k++) begin
            @(negedge clock);
            chk({tag, " busy"}, 32'(busy), 32'd1);
            chk({tag, " fin_early"}, 32'(finished), 32'd0);
            chk({tag, " hold_prod"}, 32'(product), 32'(prev_product));
            chk({tag, " hold_ovf"}, 32'(overflow), 32'(prev_overflow));
            if (k == inj) begin
                start     = 1'b1;
                mcand_in  = 8'd9;
                mplier_in = 8'd9;
            end
            @(posedge clock);
            #1;
            start = 1'b0;
        end
        @(negedge clock);
        chk({tag, " fin"}, 32'(finished), 32'd1);
        chk({tag, " busy_done"}, 32'(busy), 32'd0);
        chk({tag, " prod"}, 32'(product), 32'(exp_p));
        chk({tag, " ovf"}, 32'(overflow), 32'(exp_o));
        prev_product  = exp_p;
        prev_overflow = exp_o;
    endtask

    task automatic idle_check(input string tag, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            @(negedge clock);
            chk({tag, " idle_fin"}, 32'(finished), 32'd0);
            chk({tag, " idle_busy"}, 32'(busy), 32'd0);
        end
    endtask

    task automatic op(input string tag, input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clock);
        launch(a, b);
        track(tag, a, b, 0);
    endtask

    initial begin
        logic [N-1:0] ra, rb;
        reset     = 1'b1;
        start     = 1'b0;
        mcand_in  = '0;
        mplier_in = '0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst fin", 32'(finished), 32'd0);
        chk("rst prod", 32'(product), 32'd0);
        chk("rst ovf", 32'(overflow), 32'd0);
        reset = 1'b0;
        idle_check("post_rst", 2);

        op("t1_13x11", 8'd13, 8'd11);
        chk("t1 const", 32'(product), 32'h008F);
        idle_check("t1", 1);
        op("t2_255x255", 8'd255, 8'd255);
        chk("t2 const", 32'(product), 32'hFE01);
        op("t2_16x16", 8'd16, 8'd16);
        chk("t2b const", 32'(product), 32'h0100);
        op("t3_0x200", 8'd0, 8'd200);
        op("t3_200x0", 8'd200, 8'd0);

        // Start pulse during RUN is ignored.
        @(negedge clock);
        launch(8'd7, 8'd6);
        track("t4_ignored", 8'd7, 8'd6, 3);
        chk("t4 const", 32'(product), 32'd42);
        idle_check("t4", 3);

        // Back-to-back: start held through the DONE cycle.
        @(negedge clock);
        launch(8'd100, 8'd3);
        track("t5a", 8'd100, 8'd3, 0);
        chk("t5a const", 32'(product), 32'h012C);
        launch(8'd5, 8'd5);
        track("t5b", 8'd5, 8'd5, 0);
        chk("t5b const", 32'(product), 32'd25);
        idle_check("t5", 1);

        // Reset mid-RUN aborts without a finished pulse.
        @(negedge clock);
        launch(8'd77, 8'd55);
        repeat (3) @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        @(negedge clock);
        chk("t6 busy", 32'(busy), 32'd0);
        chk("t6 fin", 32'(finished), 32'd0);
        chk("t6 prod", 32'(product), 32'd0);
        chk("t6 ovf", 32'(overflow), 32'd0);
        prev_product  = '0;
        prev_overflow = 1'b0;
        idle_check("t6_abort", N + 2);
        op("t6_after", 8'd21, 8'd19);

        // Reset wins over a simultaneous start.
        @(negedge clock);
        reset = 1'b1;
        start = 1'b1;
        mcand_in = 8'd3;
        mplier_in = 8'd3;
        @(posedge clock);
        #1;
        reset = 1'b0;
        start = 1'b0;
        prev_product  = '0;
        prev_overflow = 1'b0;
        @(negedge clock);
        chk("t6b prod", 32'(product), 32'd0);
        idle_check("t6b", N + 2);

        // Randomized operations, some issued back-to-back from DONE.
        for (int i = 0; i < 24; i++) begin
            ra = N'($urandom);
            rb = N'($urandom);
            if ($urandom_range(0, 1) == 0) begin
                @(negedge clock);
            end
            launch(ra, rb);
            track("rand", ra, rb, ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, N)) : 0);
        end
        idle_check("end", 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
